instr_fetch_unit: RTL

//  Fetch stage upstream of the main control decoder. Holds the PC and issues requests on a req/ack

---
 rtl/instr_fetch_unit_pkg.sv | 28 ++
 rtl/instr_fetch_unit_ifid_reg.sv | 39 +++
 rtl/instr_fetch_unit.sv | 105 ++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, opcode constants and
// the common "where to go once the memory port is free" decision.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_HOLD = 2'b10
  } fetch_state_e;

  localparam logic [3:0] OPCODE_AND  = 4'b0000;
  localparam logic [3:0] OPCODE_ORI  = 4'b0001;
  localparam logic [3:0] OPCODE_SW   = 4'b0011;
  localparam logic [3:0] OPCODE_NAND = 4'b0111;
  localparam logic [3:0] OPCODE_ADD  = 4'b1111;

  // A bubble shares the AND encoding; InstrValid=0 is what marks it as a NOP.
  localparam logic [3:0] OPCODE_NOP  = 4'b0000;

  // Once no request is outstanding: park in HOLD while a valid IF/ID entry is
  // stalled, otherwise request again if fetch is enabled.
  function automatic fetch_state_e fetch_next(input logic en, input logic stall,
                                              input logic iv_nx);
    if (stall && iv_nx) return S_HOLD;
    return en ? S_REQ : S_IDLE;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_ifid_reg.sv
// IF/ID holding register. Flush beats load; with neither, contents are held.
// OpCode is derived from registered state only, so it is stable between
// posedges and safe to decode on the negedge.
module instr_fetch_unit_ifid_reg
  import instr_fetch_unit_pkg::*;
#(
  parameter int IW = 16,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          flush,
  input  logic [IW-1:0] d_instr,
  input  logic [AW-1:0] d_pc,
  output logic          valid,
  output logic [IW-1:0] instr,
  output logic [AW-1:0] pc,
  output logic [3:0]    opcode
);

  // Load a fetched word, or invalidate on redirect; instr/pc are kept on flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= d_instr;
      pc    <= d_pc;
    end
  end

  assign opcode = valid ? instr[IW-1:IW-4] : OPCODE_NOP;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, req/ack fetch FSM, redirect handling with a drop flag for
// in-flight words, and the IF/ID register feeding the control decoder.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int            IW       = 16,
  parameter int            AW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          Clk,
  input  logic          RstN,
  input  logic          EnIM,
  input  logic          PCSrc,
  input  logic [AW-1:0] BranchTarget,
  input  logic          Stall,
  output logic          ImReq,
  output logic [AW-1:0] ImAddr,
  input  logic          ImAck,
  input  logic [IW-1:0] ImData,
  output logic          InstrValid,
  output logic [IW-1:0] Instr,
  output logic [3:0]    OpCode,
  output logic [AW-1:0] PCOut,
  output logic [AW-1:0] PCPlus1
);

  fetch_state_e  state, state_nx;
  logic [1:0]    rst_sync;
  logic          irst_n;
  logic [AW-1:0] pc, pc_nx, addr;
  logic          drop;
  logic          take;
  logic          iv_nx;
  logic          req_start;

  // Reset asserts asynchronously and releases two edges later, clean to Clk.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) rst_sync <= 2'b00;
    else       rst_sync <= {rst_sync[0], 1'b1};
  end
  assign irst_n = rst_sync[1];

  // FSM state register.
  always_ff @(posedge Clk or negedge irst_n) begin
    if (!irst_n) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Next state: an outstanding request is never abandoned, only completed.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_HOLD: state_nx = fetch_next(EnIM, Stall, iv_nx);
      S_REQ:          if (ImAck) state_nx = fetch_next(EnIM, Stall, iv_nx);
      default:        state_nx = S_IDLE;
    endcase
  end

  // FSM outputs: request strobe and whether the returning word is accepted.
  // A word arriving while a valid entry is stalled is not taken; its address
  // is fetched again once the stall clears.
  always_comb begin
    ImReq = 1'b0;
    take  = 1'b0;
    if (state == S_REQ) begin
      ImReq = 1'b1;
      take  = ImAck && !drop && !PCSrc && !(Stall && InstrValid);
    end
  end

  assign iv_nx     = PCSrc ? 1'b0 : (take ? 1'b1 : InstrValid);
  assign pc_nx     = PCSrc ? BranchTarget : (take ? pc + 1'b1 : pc);
  assign req_start = (state_nx == S_REQ) && !((state == S_REQ) && !ImAck);

  // PC, held request address and the discard flag for redirected in-flight words.
  always_ff @(posedge Clk or negedge irst_n) begin
    if (!irst_n) begin
      pc   <= RESET_PC;
      addr <= RESET_PC;
      drop <= 1'b0;
    end else begin
      pc <= pc_nx;
      if (req_start) addr <= pc_nx;
      if ((state == S_REQ) && ImAck)  drop <= 1'b0;
      else if ((state == S_REQ) && PCSrc) drop <= 1'b1;
    end
  end

  assign ImAddr  = addr;
  assign PCPlus1 = PCOut + 1'b1;

  instr_fetch_unit_ifid_reg #(.IW(IW), .AW(AW)) u_ifid_reg (
    .clk     (Clk),
    .rst_n   (irst_n),
    .load    (take),
    .flush   (PCSrc),
    .d_instr (ImData),
    .d_pc    (pc),
    .valid   (InstrValid),
    .instr   (Instr),
    .pc      (PCOut),
    .opcode  (OpCode)
  );

endmodule
